ad9265_cfg_seq: RTL
===================

# ad9265_cfg_seq

Configuration sequencer for the AD9265 ADC serial port. Sits directly in front of the 24-bit SPI write engine: after reset it waits out ADC power-up, walks a fixed table of register writes, issues each as a one-cycle 24-bit word request and waits for the engine's completion pulse. It also arbitrates single user register writes from the control plane into the same engine, and reports busy/done/error status.

## Interface

- PWRUP_CYC, 16'd50000: cycles from reset release to first table write.
- GAP_CYC, 8'd20: idle cycles between completion pulse and the next word request.
- RST_WAIT_CYC, 16'd1000: gap after the soft-reset word, used in place of GAP_CYC.
- TIMEOUT_CYC, 16'd4095: max cycles waiting for completion before error.
- clk  in  1  system clock, same clock as SPI engine.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse: rerun the full table.
- usr_wr_req  in  1  level request for a user write; held until usr_wr_ack.
- usr_wr_addr  in  13  user register address.
- usr_wr_data  in  8  user register data.
- usr_wr_ack  out  1  one-cycle pulse: user write and its transfer word completed.
- spi_data_en  out  1  one-cycle word request to SPI engine.
- spi_data  out  24  word = {1'b0 (write), 2'b00 (1 byte), addr[12:0], data[7:0]}.
- spi_conf_ok  in  1  one-cycle completion pulse from SPI engine.
- cfg_busy  out  1  high whenever a table or user sequence is in progress.
- cfg_done  out  1  high after table completed without error; cleared on cfg_start.
- cfg_err  out  1  sticky: a timeout occurred; cleared on cfg_start or reset.

## Operation

- Table (index 0..4, fixed): 0:{0x000,0x3C} soft reset; 1:{0x008,0x00} normal power; 2:{0x014,0x01} two's-complement output; 3:{0x016,0x00} clock phase; 4:{0x0FF,0x01} transfer.
- States: PWRUP, IDLE, ISSUE, WAIT, GAP, DONE.
- PWRUP: count PWRUP_CYC cycles, then ISSUE with idx=0, mode=TABLE. Auto-start; no external trigger needed.
- ISSUE: drive spi_data for current word, spi_data_en=1 for exactly one cycle, go WAIT, clear timeout counter.
- WAIT: on spi_conf_ok go GAP (load RST_WAIT_CYC if TABLE idx==0, else GAP_CYC). If timeout counter reaches TIMEOUT_CYC: set cfg_err, drop mode, go IDLE (cfg_done stays 0; no ack for user).
- GAP: count down; at zero: TABLE mode idx<4 -> idx+1, ISSUE; TABLE idx==4 -> DONE. USER mode word 0 -> ISSUE transfer word {0x0FF,0x01}; USER word 1 -> pulse usr_wr_ack, IDLE.
- DONE: set cfg_done, go IDLE next cycle.
- IDLE: cfg_start -> clear cfg_done/cfg_err, idx=0, mode=TABLE, ISSUE. Else usr_wr_req -> latch addr/data, mode=USER, ISSUE.
- Arbitration: cfg_start beats usr_wr_req in the same cycle; user request stays pending and is served after table. cfg_start outside IDLE ignored. usr_wr_req outside IDLE is not latched until IDLE.
- spi_conf_ok outside WAIT ignored.
- spi_data holds last issued word until next ISSUE.

## Timing

- Reset values: spi_data_en=0, spi_data=0, usr_wr_ack=0, cfg_busy=1 (PWRUP counts as busy), cfg_done=0, cfg_err=0; state PWRUP.
- Reset mid-sequence: immediately back to PWRUP, all outputs to reset values.
- spi_data_en registered; spi_data valid in the same cycle as spi_data_en.
- Word-to-word spacing: spi_conf_ok cycle + GAP_CYC + 1 cycles to next spi_data_en.
- cfg_busy low only in IDLE; DONE cycle still busy; cfg_done rises in the cycle cfg_busy falls.
- usr_wr_ack asserted one cycle, in the cycle leaving GAP to IDLE; requester must drop usr_wr_req on ack; if still high the next cycle it is a new request.
- Timeout counter 16 bits, saturating; error declared when count == TIMEOUT_CYC.

## Test plan

- Power-up: release reset, engine model answers spi_conf_ok 200 cycles after each en -> first spi_data_en at cycle PWRUP_CYC+1 with 0x00003C; then 0x000800, 0x001401, 0x001600, 0x00FF01; cfg_done=1, cfg_busy=0, cfg_err=0.
- Gaps: measure spacing -> RST_WAIT_CYC+1 after word 0 completion, GAP_CYC+1 after others.
- User write: in IDLE hold usr_wr_req, addr=0x018, data=0x04 -> words 0x001804 then 0x00FF01, single usr_wr_ack after second completion.
- Collision: cfg_start and usr_wr_req same cycle -> full 5-word table first, then user word pair and ack; cfg_start during busy ignored.
- Timeout: engine never answers word 2 -> cfg_err=1 after TIMEOUT_CYC cycles, cfg_done=0, IDLE; cfg_start clears cfg_err and reruns table.
- Async reset asserted during WAIT of word 3 -> outputs at reset values immediately; sequence restarts from PWRUP and word 0.

Source files
------------

// File: rtl/ad9265_cfg_seq.sv
// AD9265 serial-port configuration sequencer: power-up wait, fixed register table,
// and single user writes into a shared 24-bit SPI write engine.
module ad9265_cfg_seq #(
  parameter logic [15:0] PWRUP_CYC    = 16'd50000,
  parameter logic [7:0]  GAP_CYC      = 8'd20,
  parameter logic [15:0] RST_WAIT_CYC = 16'd1000,
  parameter logic [15:0] TIMEOUT_CYC  = 16'd4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        usr_wr_req,
  input  logic [12:0] usr_wr_addr,
  input  logic [7:0]  usr_wr_data,
  output logic        usr_wr_ack,
  output logic        spi_data_en,
  output logic [23:0] spi_data,
  input  logic        spi_conf_ok,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        user_q, user_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic        en_q, en_d;
  logic [23:0] word_q, word_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // In user mode idx 0 is the requested write and idx 1 the transfer word.
  function automatic logic [23:0] word_of(input logic        user,
                                          input logic [2:0]  idx,
                                          input logic [12:0] addr,
                                          input logic [7:0]  data);
    logic [12:0] a;
    logic [7:0]  d;
    a = 13'h0FF;
    d = 8'h01;
    if (user) begin
      if (idx == 3'd0) begin
        a = addr;
        d = data;
      end
    end else begin
      case (idx)
        3'd0:    begin a = 13'h000; d = 8'h3C; end
        3'd1:    begin a = 13'h008; d = 8'h00; end
        3'd2:    begin a = 13'h014; d = 8'h01; end
        3'd3:    begin a = 13'h016; d = 8'h00; end
        default: begin a = 13'h0FF; d = 8'h01; end
      endcase
    end
    return {1'b0, 2'b00, a, d};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      user_q  <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      en_q    <= 1'b0;
      word_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      user_q  <= user_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      en_q    <= en_d;
      word_q  <= word_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    user_d     = user_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    done_d     = done_q;
    err_d      = err_q;
    en_d       = 1'b0;
    word_d     = word_q;
    usr_wr_ack = 1'b0;

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == PWRUP_CYC) begin
          state_d = S_ISSUE;
          idx_d   = 3'd0;
          user_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (cfg_start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = 3'd0;
          user_d  = 1'b0;
          state_d = S_ISSUE;
        end else if (usr_wr_req) begin
          addr_d  = usr_wr_addr;
          wdat_d  = usr_wr_data;
          idx_d   = 3'd0;
          user_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi_conf_ok) begin
          cnt_d   = (!user_q && idx_q == 3'd0) ? RST_WAIT_CYC : {8'd0, GAP_CYC};
          state_d = S_GAP;
        end else if (cnt_q == TIMEOUT_CYC) begin
          err_d   = 1'b1;
          user_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        // Leaving on count 1 makes the next request land exactly gap+1 cycles after completion.
        if (cnt_q <= 16'd1) begin
          if (!user_q) begin
            if (idx_q == 3'd4) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = S_ISSUE;
            end
          end else if (idx_q == 3'd0) begin
            idx_d   = 3'd1;
            state_d = S_ISSUE;
          end else begin
            usr_wr_ack = 1'b1;
            user_d     = 1'b0;
            state_d    = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_PWRUP;
    endcase

    // Word and strobe are registered together so spi_data is valid with spi_data_en.
    if (state_d == S_ISSUE) begin
      en_d   = 1'b1;
      word_d = word_of(user_d, idx_d, addr_d, wdat_d);
    end
  end

  assign spi_data_en = en_q;
  assign spi_data    = word_q;
  assign cfg_busy    = (state_q != S_IDLE);
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;

endmodule
